// File: rtl/bsr_block_sched.sv
// bsr_block_sched
//   Walks a BSR sparsity pattern (row_ptr[] and col_idx[] arrays of 32-bit
//   words in memory) and emits one descriptor per non-zero block to the
//   spmm_bsr stage.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   start                           begin a walk (sampled only in IDLE)
//   num_block_rows, num_block_cols  pattern geometry (latched on start)
//   row_ptr_base, col_idx_base      byte base addresses (latched on start)
//   mem_req_*/mem_rsp_*             single-outstanding read port
//   desc_*                          descriptor valid/ready channel
//   busy, done, err, blocks_issued  status
module bsr_block_sched #(
  parameter int unsigned IDX_W  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [IDX_W-1:0]  num_block_rows,
  input  logic [IDX_W-1:0]  num_block_cols,
  input  logic [ADDR_W-1:0] row_ptr_base,
  input  logic [ADDR_W-1:0] col_idx_base,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [IDX_W-1:0]  desc_row,
  output logic [IDX_W-1:0]  desc_col,
  output logic [31:0]       desc_nnz,
  output logic              desc_last_in_row,
  output logic              desc_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       blocks_issued
);

  typedef enum logic [3:0] {
    S_IDLE, S_RP0_REQ, S_RP0_WAIT, S_RP_REQ, S_RP_WAIT,
    S_CI_REQ, S_CI_WAIT, S_EMIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  nbr_q, nbr_d;
  logic [IDX_W-1:0]  nbc_q, nbc_d;
  logic [ADDR_W-1:0] rp_base_q, rp_base_d;
  logic [ADDR_W-1:0] ci_base_q, ci_base_d;
  logic [IDX_W-1:0]  r_q, r_d;
  logic [31:0]       ptr_lo_q, ptr_lo_d;
  logic [31:0]       ptr_hi_q, ptr_hi_d;
  logic [31:0]       k_q, k_d;
  logic [IDX_W-1:0]  drow_q, drow_d;
  logic [IDX_W-1:0]  dcol_q, dcol_d;
  logic [31:0]       dnnz_q, dnnz_d;
  logic              dlir_q, dlir_d;
  logic              dlast_q, dlast_d;
  logic              err_q, err_d;
  logic [31:0]       blocks_q, blocks_d;

  logic last_row;
  logic more_in_row;
  logic advance;

  assign last_row    = (r_q == nbr_q - IDX_W'(1));
  assign more_in_row = ((k_q + 32'd1) < ptr_hi_q);

  always_comb begin
    state_d   = state_q;
    nbr_d     = nbr_q;
    nbc_d     = nbc_q;
    rp_base_d = rp_base_q;
    ci_base_d = ci_base_q;
    r_d       = r_q;
    ptr_lo_d  = ptr_lo_q;
    ptr_hi_d  = ptr_hi_q;
    k_d       = k_q;
    drow_d    = drow_q;
    dcol_d    = dcol_q;
    dnnz_d    = dnnz_q;
    dlir_d    = dlir_q;
    dlast_d   = dlast_q;
    err_d     = err_q;
    blocks_d  = blocks_q;
    advance   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nbr_d     = num_block_rows;
          nbc_d     = num_block_cols;
          rp_base_d = row_ptr_base;
          ci_base_d = col_idx_base;
          err_d     = 1'b0;
          blocks_d  = '0;
          r_d       = '0;
          ptr_lo_d  = '0;
          ptr_hi_d  = '0;
          state_d   = (num_block_rows == '0) ? S_DONE : S_RP0_REQ;
        end
      end
      S_RP0_REQ: if (mem_req_ready) state_d = S_RP0_WAIT;
      S_RP0_WAIT: begin
        if (mem_rsp_valid) begin
          ptr_lo_d = mem_rsp_data;
          state_d  = S_RP_REQ;
        end
      end
      S_RP_REQ: if (mem_req_ready) state_d = S_RP_WAIT;
      S_RP_WAIT: begin
        if (mem_rsp_valid) begin
          ptr_hi_d = mem_rsp_data;
          if (mem_rsp_data < ptr_lo_q) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (mem_rsp_data == ptr_lo_q) begin
            advance = 1'b1;
          end else begin
            k_d     = ptr_lo_q;
            state_d = S_CI_REQ;
          end
        end
      end
      S_CI_REQ: if (mem_req_ready) state_d = S_CI_WAIT;
      S_CI_WAIT: begin
        if (mem_rsp_valid) begin
          if ((mem_rsp_data[IDX_W-1:0] >= nbc_q) || ((mem_rsp_data >> IDX_W) != '0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            drow_d  = r_q;
            dcol_d  = mem_rsp_data[IDX_W-1:0];
            dnnz_d  = k_q;
            dlir_d  = !more_in_row;
            dlast_d = !more_in_row && last_row;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (desc_ready) begin
          blocks_d = blocks_q + 32'd1;
          if (more_in_row) begin
            k_d     = k_q + 32'd1;
            state_d = S_CI_REQ;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Row advance is shared by the empty-row path (RP_WAIT) and the
    // end-of-row path (EMIT); ptr_hi_d already holds the new row end.
    if (advance) begin
      ptr_lo_d = ptr_hi_d;
      r_d      = r_q + IDX_W'(1);
      state_d  = last_row ? S_DONE : S_RP_REQ;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      nbr_q     <= '0;
      nbc_q     <= '0;
      rp_base_q <= '0;
      ci_base_q <= '0;
      r_q       <= '0;
      ptr_lo_q  <= '0;
      ptr_hi_q  <= '0;
      k_q       <= '0;
      drow_q    <= '0;
      dcol_q    <= '0;
      dnnz_q    <= '0;
      dlir_q    <= 1'b0;
      dlast_q   <= 1'b0;
      err_q     <= 1'b0;
      blocks_q  <= '0;
    end else begin
      state_q   <= state_d;
      nbr_q     <= nbr_d;
      nbc_q     <= nbc_d;
      rp_base_q <= rp_base_d;
      ci_base_q <= ci_base_d;
      r_q       <= r_d;
      ptr_lo_q  <= ptr_lo_d;
      ptr_hi_q  <= ptr_hi_d;
      k_q       <= k_d;
      drow_q    <= drow_d;
      dcol_q    <= dcol_d;
      dnnz_q    <= dnnz_d;
      dlir_q    <= dlir_d;
      dlast_q   <= dlast_d;
      err_q     <= err_d;
      blocks_q  <= blocks_d;
    end
  end

  // Request address is a pure function of registered state, so it is
  // stable for as long as a request is pending.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (state_q)
      S_RP0_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = rp_base_q;
      end
      S_RP_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = rp_base_q + ((ADDR_W'(r_q) + ADDR_W'(1)) << 2);
      end
      S_CI_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ci_base_q + (ADDR_W'(k_q) << 2);
      end
      default: ;
    endcase
  end

  assign desc_valid       = (state_q == S_EMIT);
  assign desc_row         = drow_q;
  assign desc_col         = dcol_q;
  assign desc_nnz         = dnnz_q;
  assign desc_last_in_row = dlir_q;
  assign desc_last        = dlast_q;
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done             = (state_q == S_DONE);
  assign err              = err_q;
  assign blocks_issued    = blocks_q;

endmodule
